// File: rtl/clock_setter_pkg.sv
// ============================================================================
// clock_setter_pkg : shared types, limits and wrap arithmetic for the time setter
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_setter_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    EDIT_H = 3'd1,
    EDIT_M = 3'd2,
    EDIT_S = 3'd3,
    COMMIT = 3'd4
  } setter_state_t;

  localparam logic [5:0] MAX_HORAS   = 6'd23;
  localparam logic [5:0] MAX_MIN_SEG = 6'd59;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_H    = 2'd1;
  localparam logic [1:0] FIELD_M    = 2'd2;
  localparam logic [1:0] FIELD_S    = 2'd3;

  // Simultaneous up and down cancel out; no carry leaves the field.
  function automatic logic [5:0] edit_value(input logic [5:0] value,
                                            input logic [5:0] max_value,
                                            input logic       up,
                                            input logic       down);
    logic [5:0] result;
    result = value;
    if (up && !down)
      result = (value >= max_value) ? 6'd0 : value + 6'd1;
    else if (down && !up)
      result = (value == 6'd0) ? max_value : value - 6'd1;
    return result;
  endfunction

  function automatic logic [5:0] clamp_capture(input logic [5:0] value,
                                               input logic [5:0] max_value);
    return (value > max_value) ? 6'd0 : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// button_debouncer : 2-FF sync, stability debounce and one-cycle press event
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_100MHz,
  input  logic rstn,
  input  logic btn,
  output logic press
);

  localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
      press      <= 1'b0;
    end else begin
      r_sync1    <= btn;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      press      <= r_stable & ~r_stable_d;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_time_setter.sv
// ============================================================================
// clock_time_setter : button-driven edit session producing pause/load for the clock counter
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_time_setter
  import clock_setter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk_100MHz,
  input  logic       rstn,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [5:0] horas,
  input  logic [5:0] minutos,
  input  logic [5:0] segundos,
  output logic       pause,
  output logic       load,
  output logic [5:0] load_horas,
  output logic [5:0] load_minutos,
  output logic [5:0] load_segundos,
  output logic [1:0] edit_field
);

  logic w_mode_ev;
  logic w_up_ev;
  logic w_down_ev;

  setter_state_t r_state;
  logic [5:0]    r_edit_h;
  logic [5:0]    r_edit_m;
  logic [5:0]    r_edit_s;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clk_100MHz (clk_100MHz),
    .rstn       (rstn),
    .btn        (btn_mode),
    .press      (w_mode_ev)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk_100MHz (clk_100MHz),
    .rstn       (rstn),
    .btn        (btn_up),
    .press      (w_up_ev)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk_100MHz (clk_100MHz),
    .rstn       (rstn),
    .btn        (btn_down),
    .press      (w_down_ev)
  );

  // The edit registers are the load value; they only change inside an edit session.
  assign load_horas    = r_edit_h;
  assign load_minutos  = r_edit_m;
  assign load_segundos = r_edit_s;

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      r_state    <= RUN;
      r_edit_h   <= '0;
      r_edit_m   <= '0;
      r_edit_s   <= '0;
      pause      <= 1'b0;
      load       <= 1'b0;
      edit_field <= FIELD_NONE;
    end else begin
      load <= 1'b0;
      case (r_state)
        RUN: begin
          pause      <= 1'b0;
          edit_field <= FIELD_NONE;
          if (w_mode_ev) begin
            r_edit_h   <= clamp_capture(horas, MAX_HORAS);
            r_edit_m   <= clamp_capture(minutos, MAX_MIN_SEG);
            r_edit_s   <= clamp_capture(segundos, MAX_MIN_SEG);
            r_state    <= EDIT_H;
            pause      <= 1'b1;
            edit_field <= FIELD_H;
          end
        end
        EDIT_H: begin
          r_edit_h <= edit_value(r_edit_h, MAX_HORAS, w_up_ev, w_down_ev);
          if (w_mode_ev) begin
            r_state    <= EDIT_M;
            edit_field <= FIELD_M;
          end
        end
        EDIT_M: begin
          r_edit_m <= edit_value(r_edit_m, MAX_MIN_SEG, w_up_ev, w_down_ev);
          if (w_mode_ev) begin
            r_state    <= EDIT_S;
            edit_field <= FIELD_S;
          end
        end
        EDIT_S: begin
          r_edit_s <= edit_value(r_edit_s, MAX_MIN_SEG, w_up_ev, w_down_ev);
          if (w_mode_ev) begin
            r_state    <= COMMIT;
            load       <= 1'b1;
            edit_field <= FIELD_NONE;
          end
        end
        COMMIT: begin
          r_state    <= RUN;
          pause      <= 1'b0;
          edit_field <= FIELD_NONE;
        end
        default: begin
          r_state    <= RUN;
          pause      <= 1'b0;
          edit_field <= FIELD_NONE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
